i2c_bus_master: RTL and testbench

- Single-master I2C bus controller, open-drain on SDA/SCL with external pull-ups.
- On a `start` request it performs one single-byte transaction: START, 7-bit address + R/W, ACK check, then one data byte written or read, then STOP.
- It sits between system logic (address/data/mode inputs) and the shared two-wire bus that the slave devices attach to.

---
 rtl/i2c_bus_master_if.sv | 16 +
 rtl/i2c_bus_master.sv | 153 +++++++++++++++
 tb/tb_i2c_bus_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_master_if.sv
// System-side request/response bundle for the I2C bus master.
// The master modport is the requesting logic; the slave modport is the controller itself.
interface i2c_bus_master_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] din;
  logic [ADDR_WIDTH-1:0] address;
  logic                  rd_wr;
  logic                  start;
  logic                  stop;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output din, address, rd_wr, start, stop, input dout);
  modport slave  (input din, address, rd_wr, start, stop, output dout);
endinterface

// File: rtl/i2c_bus_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, STOP.
// Open-drain outputs; each SCL bit is four quarter-phases of QTR_DIV clocks.
module i2c_bus_master #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int QTR_DIV    = 1
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire               SDA,
  inout  wire               SCL,
  i2c_bus_master_if.slave   bus
);

  localparam int FW = ADDR_WIDTH + 1;
  localparam int MW = (FW > DATA_WIDTH) ? FW : DATA_WIDTH;
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;
  localparam int QW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
    S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT, S_STOP
  } state_t;

  state_t                state_q;
  logic [1:0]            phase_q;
  logic [QW-1:0]         qcnt_q;
  logic [QW-1:0]         qcnt_d;
  logic [CW-1:0]         bit_cnt_q;
  logic [FW-1:0]         frame_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  sda_oe_q;
  logic                  scl_oe_q;
  logic                  nack_q;
  logic                  qtick;
  logic                  last_bit;
  logic                  bit_state;
  logic                  sda_in;

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign SCL      = scl_oe_q ? 1'b0 : 1'bz;
  assign sda_in   = SDA;
  assign bus.dout = dout_q;

  assign qtick     = (qcnt_q == QW'(QTR_DIV - 1));
  assign qcnt_d    = qtick ? '0 : qcnt_q + QW'(1);
  assign last_bit  = (bit_cnt_q == '0);
  assign bit_state = (state_q == S_ADDR) || (state_q == S_ADDR_ACK) ||
                     (state_q == S_WRITE) || (state_q == S_WRITE_ACK) ||
                     (state_q == S_READ) || (state_q == S_READ_ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 2'd0;
      qcnt_q    <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      data_q    <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      sda_oe_q  <= 1'b0;
      scl_oe_q  <= 1'b0;
      nack_q    <= 1'b0;
    end else if (state_q == S_IDLE) begin
      qcnt_q  <= '0;
      phase_q <= 2'd0;
      if (bus.start) begin
        frame_q <= {bus.address, bus.rd_wr};
        data_q  <= bus.din;
        state_q <= S_START;
      end
    end else begin
      qcnt_q <= qcnt_d;
      if (qtick) begin
        phase_q <= phase_q + 2'd1;
        // Every data/ack bit shares the same SCL waveform: release at q1, pull at q3.
        if (bit_state && phase_q == 2'd1) scl_oe_q <= 1'b0;
        if (bit_state && phase_q == 2'd3) scl_oe_q <= 1'b1;

        case (state_q)
          S_START: begin
            if (phase_q == 2'd0) begin
              sda_oe_q <= 1'b1;
            end else begin
              scl_oe_q  <= 1'b1;
              phase_q   <= 2'd0;
              bit_cnt_q <= CW'(FW - 1);
              state_q   <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (phase_q == 2'd0) sda_oe_q <= ~frame_q[bit_cnt_q];
            if (phase_q == 2'd3) begin
              if (last_bit) state_q <= S_ADDR_ACK;
              else          bit_cnt_q <= bit_cnt_q - CW'(1);
            end
          end
          S_ADDR_ACK: begin
            if (phase_q == 2'd0) sda_oe_q <= 1'b0;
            if (phase_q == 2'd2) nack_q <= sda_in;
            if (phase_q == 2'd3) begin
              bit_cnt_q <= CW'(DATA_WIDTH - 1);
              if (nack_q)          state_q <= S_STOP;
              else if (frame_q[0]) state_q <= S_READ;
              else                 state_q <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (phase_q == 2'd0) sda_oe_q <= ~data_q[bit_cnt_q];
            if (phase_q == 2'd3) begin
              if (last_bit) state_q <= S_WRITE_ACK;
              else          bit_cnt_q <= bit_cnt_q - CW'(1);
            end
          end
          S_READ: begin
            if (phase_q == 2'd0) sda_oe_q <= 1'b0;
            if (phase_q == 2'd2) begin
              rx_q <= {rx_q[DATA_WIDTH-2:0], sda_in};
              if (last_bit) dout_q <= {rx_q[DATA_WIDTH-2:0], sda_in};
            end
            if (phase_q == 2'd3) begin
              if (last_bit) state_q <= S_READ_ACK;
              else          bit_cnt_q <= bit_cnt_q - CW'(1);
            end
          end
          S_WRITE_ACK, S_READ_ACK: begin
            // Released SDA doubles as the master NACK that ends a single-byte read.
            if (phase_q == 2'd0) sda_oe_q <= 1'b0;
            if (phase_q == 2'd3) state_q <= S_WAIT;
          end
          S_WAIT: begin
            phase_q <= 2'd0;
            if (bus.stop) state_q <= S_STOP;
          end
          S_STOP: begin
            if (phase_q == 2'd0) sda_oe_q <= 1'b1;
            if (phase_q == 2'd1) scl_oe_q <= 1'b0;
            if (phase_q == 2'd2) begin
              sda_oe_q <= 1'b0;
              phase_q  <= 2'd0;
              state_q  <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_master.sv
// Directed bench for i2c_bus_master: a passive bus monitor plus a simple slave at 7'h50,
// with expected bus events queued at stimulus time and compared against the monitor log.
module tb_i2c_bus_master;

  localparam int EV_START = 32'h100;
  localparam int EV_ACK   = 32'h200;
  localparam int EV_STOP  = 32'h300;
  localparam logic [6:0] SLV_ADDR = 7'h50;

  logic clk;
  logic reset;
  wire  sda_w;
  wire  scl_w;
  logic slv_oe;

  i2c_bus_master_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus_if ();

  i2c_bus_master #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .QTR_DIV(1)) dut (
    .clk   (clk),
    .reset (reset),
    .SDA   (sda_w),
    .SCL   (scl_w),
    .bus   (bus_if)
  );

  pullup (sda_w);
  pullup (scl_w);
  assign sda_w = slv_oe ? 1'b0 : 1'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          obs_q[$];
  int          exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  rd_byte;
  logic [7:0]  slv_wr_byte;
  int          slv_wr_cnt;

  // Monitor and slave responder share one process; it alone writes obs_q and slv_*.
  initial begin
    logic       sda_s, scl_s, sda_p, scl_p, addressed;
    logic [8:0] sh;
    logic [7:0] addr_byte;
    int         cnt;
    sda_p = 1'b1; scl_p = 1'b1; addressed = 1'b0; sh = '0; addr_byte = '0; cnt = 0;
    slv_oe = 1'b0; slv_wr_byte = '0; slv_wr_cnt = 0;
    forever begin
      @(negedge clk);
      sda_s = sda_w;
      scl_s = scl_w;
      if (scl_s && scl_p && sda_p && !sda_s) begin
        obs_q.push_back(EV_START);
        cnt = 0; slv_oe = 1'b0; addressed = 1'b0;
      end else if (scl_s && scl_p && !sda_p && sda_s) begin
        obs_q.push_back(EV_STOP);
        cnt = 0; slv_oe = 1'b0;
      end else if (!scl_p && scl_s) begin
        sh = {sh[7:0], sda_s};
        cnt++;
        if (cnt % 9 == 8) obs_q.push_back(int'(sh[7:0]));
        if (cnt % 9 == 0 && cnt > 0) obs_q.push_back(EV_ACK | int'(sh[0]));
      end else if (scl_p && !scl_s) begin
        if (cnt == 8) begin
          addr_byte = sh[7:0];
          addressed = (addr_byte[7:1] == SLV_ADDR);
          slv_oe    = addressed;
        end else if (cnt == 9) begin
          slv_oe = addressed && addr_byte[0] && !rd_byte[7];
        end else if (addressed && addr_byte[0] && cnt >= 10 && cnt <= 16) begin
          slv_oe = !rd_byte[7 - (cnt - 9)];
        end else if (cnt == 17) begin
          slv_oe = 1'b0;
          if (addressed && !addr_byte[0]) begin
            slv_wr_byte = sh[7:0];
            slv_wr_cnt++;
            slv_oe = 1'b1;
          end
        end else if (cnt == 18) begin
          slv_oe = 1'b0;
        end
      end
      sda_p = sda_s;
      scl_p = scl_s;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input string tag, input int v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic wait_obs(input int target, input string tag);
    int k = 0;
    while (obs_q.size() < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    assert (obs_q.size() >= target) else begin
      n_err++;
      $error("FAIL %s timeout: observed %0d events expected %0d", tag, obs_q.size(), target);
    end
  endtask

  task automatic drain_expected(input int base);
    int i = 0;
    while (exp_q.size() > 0) begin
      int    e;
      string t;
      int    o;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = (base + i < obs_q.size()) ? obs_q[base + i] : -1;
      check(t, 32'(o), 32'(e));
      i++;
    end
  endtask

  task automatic launch(input logic [6:0] a, input logic rw, input logic [7:0] d, input logic stp);
    @(negedge clk);
    bus_if.address = a;
    bus_if.rd_wr   = rw;
    bus_if.din     = d;
    bus_if.stop    = stp;
    bus_if.start   = 1'b1;
    @(negedge clk);
    bus_if.start   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    reset = 1'b0;
    bus_if.start = 1'b0; bus_if.stop = 1'b1; bus_if.rd_wr = 1'b0;
    bus_if.address = '0; bus_if.din = '0;
    rd_byte = 8'h3C;
    idle(3);
    check("reset_sda", {31'd0, sda_w}, 32'd1);
    check("reset_scl", {31'd0, scl_w}, 32'd1);
    check("reset_dout", 32'(bus_if.dout), 32'h0);
    reset = 1'b1;
    idle(20);
    check("idle_no_start", 32'(obs_q.size()), 32'd0);

    // Write 0xA5 to 0x50
    base = obs_q.size();
    expect_ev("wr_start", EV_START); expect_ev("wr_addr", 32'hA0); expect_ev("wr_aack", EV_ACK);
    expect_ev("wr_data", 32'hA5);    expect_ev("wr_dack", EV_ACK); expect_ev("wr_stop", EV_STOP);
    launch(7'h50, 1'b0, 8'hA5, 1'b1);
    wait_obs(base + 6, "wr");
    drain_expected(base);
    check("wr_slave_byte", 32'(slv_wr_byte), 32'hA5);
    check("wr_dout_untouched", 32'(bus_if.dout), 32'h0);

    // Read 0x3C from 0x50; master NACKs the byte
    idle(5);
    base = obs_q.size();
    expect_ev("rd_start", EV_START); expect_ev("rd_addr", 32'hA1); expect_ev("rd_aack", EV_ACK);
    expect_ev("rd_data", 32'h3C);    expect_ev("rd_mnack", EV_ACK | 1); expect_ev("rd_stop", EV_STOP);
    launch(7'h50, 1'b1, 8'h00, 1'b1);
    wait_obs(base + 6, "rd");
    drain_expected(base);
    check("rd_dout", 32'(bus_if.dout), 32'h3C);

    // Address 0x22 unanswered: STOP right after the NACK, dout kept
    idle(5);
    base = obs_q.size();
    expect_ev("nk_start", EV_START); expect_ev("nk_addr", 32'h44);
    expect_ev("nk_nack", EV_ACK | 1); expect_ev("nk_stop", EV_STOP);
    launch(7'h22, 1'b0, 8'hFF, 1'b1);
    wait_obs(base + 4, "nk");
    drain_expected(base);
    check("nk_dout_kept", 32'(bus_if.dout), 32'h3C);
    check("nk_no_write", 32'(slv_wr_cnt), 32'd1);

    // stop=0 parks the bus in WAIT with SCL low until stop rises
    idle(5);
    base = obs_q.size();
    expect_ev("wt_start", EV_START); expect_ev("wt_addr", 32'hA0); expect_ev("wt_aack", EV_ACK);
    expect_ev("wt_data", 32'h5A);    expect_ev("wt_dack", EV_ACK);
    launch(7'h50, 1'b0, 8'h5A, 1'b0);
    wait_obs(base + 5, "wt");
    drain_expected(base);
    idle(40);
    check("wt_scl_held", {31'd0, scl_w}, 32'd0);
    check("wt_no_stop", 32'(obs_q.size()), 32'(base + 5));
    idle(40);
    check("wt_scl_still", {31'd0, scl_w}, 32'd0);
    bus_if.stop = 1'b1;
    expect_ev("wt_stop", EV_STOP);
    wait_obs(base + 6, "wt_stop");
    drain_expected(base + 5);
    idle(3);
    check("wt_idle_scl", {31'd0, scl_w}, 32'd1);
    check("wt_idle_sda", {31'd0, sda_w}, 32'd1);

    // start re-pulsed with different inputs mid-transfer is ignored
    base = obs_q.size();
    expect_ev("ig_start", EV_START); expect_ev("ig_addr", 32'hA0); expect_ev("ig_aack", EV_ACK);
    expect_ev("ig_data", 32'h96);    expect_ev("ig_dack", EV_ACK); expect_ev("ig_stop", EV_STOP);
    launch(7'h50, 1'b0, 8'h96, 1'b1);
    idle(20);
    bus_if.address = 7'h22; bus_if.din = 8'h00; bus_if.rd_wr = 1'b1; bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_obs(base + 6, "ig");
    drain_expected(base);
    check("ig_slave_byte", 32'(slv_wr_byte), 32'h96);
    idle(30);
    check("ig_no_second", 32'(obs_q.size()), 32'(base + 6));

    // Reset mid-address phase of a read releases the bus at once and clears dout
    launch(7'h50, 1'b1, 8'h00, 1'b1);
    idle(8);
    reset = 1'b0;
    #1;
    check("rst_mid_sda", {31'd0, sda_w}, 32'd1);
    check("rst_mid_scl", {31'd0, scl_w}, 32'd1);
    check("rst_mid_dout", 32'(bus_if.dout), 32'h0);
    idle(2);
    reset = 1'b1;
    idle(2);
    base = obs_q.size();
    idle(40);
    check("rst_stays_idle", 32'(obs_q.size()), 32'(base));
    check("rst_idle_scl", {31'd0, scl_w}, 32'd1);

    // Recovery: a normal write still works after the abort
    expect_ev("rc_start", EV_START); expect_ev("rc_addr", 32'hA0); expect_ev("rc_aack", EV_ACK);
    expect_ev("rc_data", 32'hC3);    expect_ev("rc_dack", EV_ACK); expect_ev("rc_stop", EV_STOP);
    launch(7'h50, 1'b0, 8'hC3, 1'b1);
    wait_obs(base + 6, "rc");
    drain_expected(base);
    check("rc_slave_byte", 32'(slv_wr_byte), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
